// File: rtl/mips_cpu_pkg.sv
// Shared MIPS encodings and control-FSM types used by the decoder and the
// multi-cycle control sequencer.
package mips_cpu_pkg;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
        OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
        OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
        OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f,
        OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23,
        OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_LWR   = 6'h26,
        OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SWL   = 6'h2a, OP_SW    = 6'h2b,
        OP_SWR     = 6'h2e
    } opcode_e;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV  = 6'h04,
        F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR  = 6'h09,
        F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO  = 6'h13,
        F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU  = 6'h1b,
        F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU  = 6'h23,
        F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27,
        F_SLT  = 6'h2a, F_SLTU = 6'h2b
    } funct_e;

    typedef enum logic [4:0] {
        RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11
    } regimm_e;

    typedef enum logic [2:0] {
        FETCH       = 3'd0,
        EXEC        = 3'd1,
        MEM         = 3'd2,
        MULDIV_WAIT = 3'd3,
        WB          = 3'd4,
        HALTED      = 3'd5
    } state_e;

    localparam logic PC_SRC_PC4 = 1'b0;
    localparam logic PC_SRC_TGT = 1'b1;

endpackage

// File: rtl/mips_cpu_control_fsm_if.sv
// Memory-side bus of the control sequencer: instruction/readdata in, strobes out.
interface mips_cpu_control_fsm_if;
    // A strobe (mem_read_o / mem_write_o) is the request; it stays high until a
    // cycle in which mem_waitrequest_i is low, and that cycle completes the transfer.
    logic [31:0] instr_i;
    logic        mem_waitrequest_i;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        instr_fetch_o;

    modport master (
        input  instr_i, mem_waitrequest_i,
        output mem_read_o, mem_write_o, instr_fetch_o
    );

    modport slave (
        output instr_i, mem_waitrequest_i,
        input  mem_read_o, mem_write_o, instr_fetch_o
    );
endinterface

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier: sorts an instruction word into the
// groups the control FSM sequences differently.
module mips_cpu_instr_class
    import mips_cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_jr,
    output logic        is_muldiv,
    output logic        is_div,
    output logic        writes_gpr,
    output logic        is_link,
    output logic        illegal
);

    // rs/rt/rd/shamt only matter to the datapath.
    logic unused_fields;
    assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_jr      = 1'b0;
        is_muldiv  = 1'b0;
        is_div     = 1'b0;
        writes_gpr = 1'b0;
        is_link    = 1'b0;
        illegal    = 1'b0;
        case (instr_i[31:26])
            OP_SPECIAL: begin
                case (instr_i[5:0])
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_MFHI, F_MFLO: writes_gpr = 1'b1;
                    F_JR: begin
                        is_jump = 1'b1;
                        is_jr   = 1'b1;
                    end
                    F_JALR: begin
                        is_jump = 1'b1;
                        is_jr   = 1'b1;
                        is_link = 1'b1;
                    end
                    F_MULT, F_MULTU, F_MTHI, F_MTLO: is_muldiv = 1'b1;
                    F_DIV, F_DIVU: begin
                        is_muldiv = 1'b1;
                        is_div    = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (instr_i[20:16])
                    RT_BLTZ, RT_BGEZ: is_branch = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        is_branch = 1'b1;
                        is_link   = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_J:   is_jump = 1'b1;
            OP_JAL: begin
                is_jump = 1'b1;
                is_link = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: writes_gpr = 1'b1;
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
                is_load    = 1'b1;
                writes_gpr = 1'b1;
            end
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_store = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/EXEC/MEM/MULDIV_WAIT/WB and drives strobes and write enables.
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
#(
    parameter int DELAY_SLOT = 1,
    parameter int MULT_LAT   = 4,
    parameter int DIV_LAT    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_cpu_control_fsm_if.master        bus,
    input  logic                          alu_cond_i,
    input  logic                          jr_target_zero_i,
    output logic                          ir_load_o,
    output logic                          tgt_we_o,
    output logic                          pc_we_o,
    output logic                          pc_src_o,
    output logic                          reg_write_o,
    output logic                          spc_reg_write_o,
    output logic                          active_o,
    output logic                          illegal_o,
    output logic [2:0]                    state_o
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_M1 = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic is_load, is_store, is_branch, is_jump, is_jr;
    logic is_muldiv, is_div, writes_gpr, is_link, illegal;

    mips_cpu_instr_class u_class (
        .instr_i    (bus.instr_i),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_jr      (is_jr),
        .is_muldiv  (is_muldiv),
        .is_div     (is_div),
        .writes_gpr (writes_gpr),
        .is_link    (is_link),
        .illegal    (illegal)
    );

    state_e           state_q, state_d;
    logic             arm_q, arm_d;
    logic             in_slot_q, in_slot_d;
    logic             halt_q, halt_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_read, mem_write, instr_fetch;
    logic redirect;
    logic [CNT_W-1:0] lat_m1;

    assign redirect = (is_branch & alu_cond_i) | is_jump;
    assign lat_m1   = is_div ? DIV_M1 : MULT_M1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            arm_q     <= 1'b0;
            in_slot_q <= 1'b0;
            halt_q    <= 1'b0;
            ill_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            in_slot_q <= in_slot_d;
            halt_q    <= halt_d;
            ill_q     <= ill_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        arm_d           = arm_q;
        in_slot_d       = in_slot_q;
        halt_d          = halt_q;
        ill_d           = ill_q;
        cnt_d           = cnt_q;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        instr_fetch     = 1'b0;
        ir_load_o       = 1'b0;
        tgt_we_o        = 1'b0;
        pc_we_o         = 1'b0;
        pc_src_o        = PC_SRC_PC4;
        reg_write_o     = 1'b0;
        spc_reg_write_o = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read    = 1'b1;
                instr_fetch = 1'b1;
                if (!bus.mem_waitrequest_i) begin
                    ir_load_o = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // A control transfer sitting in a delay slot is dropped entirely.
                if (redirect && !in_slot_q) begin
                    tgt_we_o = 1'b1;
                    arm_d    = 1'b1;
                    if (is_jr && jr_target_zero_i) halt_d = 1'b1;
                end
                if (illegal) ill_d = 1'b1;
                if (is_load || is_store) begin
                    state_d = MEM;
                end else if (is_muldiv) begin
                    cnt_d   = lat_m1;
                    state_d = (lat_m1 == '0) ? WB : MULDIV_WAIT;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (!bus.mem_waitrequest_i) state_d = WB;
            end
            MULDIV_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) state_d = WB;
            end
            WB: begin
                reg_write_o     = writes_gpr | is_link;
                spc_reg_write_o = is_muldiv;
                pc_we_o         = 1'b1;
                arm_d           = 1'b0;
                if (DELAY_SLOT != 0) begin
                    pc_src_o  = in_slot_q;
                    in_slot_d = arm_q;
                    state_d   = (in_slot_q && halt_q) ? HALTED : FETCH;
                end else begin
                    pc_src_o = arm_q;
                    state_d  = halt_q ? HALTED : FETCH;
                end
            end
            HALTED: ;
            default: state_d = FETCH;
        endcase
        // Reset parks the state in FETCH; keep its strobes quiet until release.
        if (!rst_n) begin
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            instr_fetch     = 1'b0;
            ir_load_o       = 1'b0;
            tgt_we_o        = 1'b0;
            pc_we_o         = 1'b0;
            pc_src_o        = PC_SRC_PC4;
            reg_write_o     = 1'b0;
            spc_reg_write_o = 1'b0;
        end
    end

    assign bus.mem_read_o    = mem_read;
    assign bus.mem_write_o   = mem_write;
    assign bus.instr_fetch_o = instr_fetch;
    assign active_o          = (state_q != HALTED);
    assign illegal_o         = ill_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Bench for mips_cpu_control_fsm: per-cycle expected output vectors are queued
// with the stimulus and compared on the falling edge.
module tb_mips_cpu_control_fsm;

    localparam int W = 14;
    localparam logic [2:0] S_FETCH = 3'd0, S_EXEC = 3'd1, S_MEM = 3'd2;
    localparam logic [2:0] S_MDW = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [10:0] RD  = 11'h400, WR  = 11'h200, IFB = 11'h100, IRL = 11'h080;
    localparam logic [10:0] TGT = 11'h040, PCW = 11'h020, PCS = 11'h010, RW  = 11'h008;
    localparam logic [10:0] SPC = 11'h004, ACT = 11'h002, ILL = 11'h001, NONE = 11'h000;

    localparam logic [31:0] I_ADDU  = 32'h00221821, I_ADDIU = 32'h24220001;
    localparam logic [31:0] I_LW    = 32'h8c220004, I_SW    = 32'hac220008;
    localparam logic [31:0] I_BEQ   = 32'h10220003, I_MULT  = 32'h00430018;
    localparam logic [31:0] I_ORI   = 32'h34420001, I_BAD   = 32'hfc000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_b_n, cond, jrz;
    mips_cpu_control_fsm_if if_a ();
    mips_cpu_control_fsm_if if_b ();

    logic a_ir, a_tgt, a_pcwe, a_pcsrc, a_rw, a_spc, a_act, a_ill;
    logic b_ir, b_tgt, b_pcwe, b_pcsrc, b_rw, b_spc, b_act, b_ill;
    logic [2:0] a_state, b_state;

    mips_cpu_control_fsm #(.DELAY_SLOT(1), .MULT_LAT(1), .DIV_LAT(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .alu_cond_i(cond), .jr_target_zero_i(jrz),
        .ir_load_o(a_ir), .tgt_we_o(a_tgt), .pc_we_o(a_pcwe), .pc_src_o(a_pcsrc),
        .reg_write_o(a_rw), .spc_reg_write_o(a_spc), .active_o(a_act),
        .illegal_o(a_ill), .state_o(a_state)
    );

    mips_cpu_control_fsm #(.DELAY_SLOT(0), .MULT_LAT(4), .DIV_LAT(32)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(if_b), .alu_cond_i(cond), .jr_target_zero_i(jrz),
        .ir_load_o(b_ir), .tgt_we_o(b_tgt), .pc_we_o(b_pcwe), .pc_src_o(b_pcsrc),
        .reg_write_o(b_rw), .spc_reg_write_o(b_spc), .active_o(b_act),
        .illegal_o(b_ill), .state_o(b_state)
    );

    logic [W-1:0] obs_a, obs_b;
    assign obs_a = {a_state, if_a.mem_read_o, if_a.mem_write_o, if_a.instr_fetch_o, a_ir,
                    a_tgt, a_pcwe, a_pcsrc, a_rw, a_spc, a_act, a_ill};
    assign obs_b = {b_state, if_b.mem_read_o, if_b.mem_write_o, if_b.instr_fetch_o, b_ir,
                    b_tgt, b_pcwe, b_pcsrc, b_rw, b_spc, b_act, b_ill};

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [34:0]  stim_q[$];
    int checks = 0;
    int errors = 0;
    bit b_on = 1'b0;
    bit ill_exp = 1'b0;

    task automatic drive(input logic [31:0] ins, input logic wreq);
        if_a.instr_i = ins;
        if_b.instr_i = ins;
        if_a.mem_waitrequest_i = wreq;
        if_b.mem_waitrequest_i = wreq;
    endtask

    task automatic push(input logic [31:0] ins, input logic c, input logic j, input logic wreq,
                        input logic [2:0] st, input logic [10:0] bits_a, input logic [10:0] bits_b);
        logic [10:0] ba;
        ba = bits_a | (ill_exp ? ILL : NONE) | ((st == S_HALT) ? NONE : ACT);
        stim_q.push_back({c, j, wreq, ins});
        exp_q.push_back({st, ba});
        if (b_on) exp_b_q.push_back({st, bits_b | ACT});
    endtask

    // One instruction: fw fetch waits, mw memory waits (<0: no MEM), lw MULDIV_WAIT cycles.
    task automatic sched(input logic [31:0] ins, input logic c, input logic j, input int fw,
                         input int mw, input int lw, input logic [10:0] ex, input logic [10:0] mb,
                         input logic [10:0] wb_a, input logic [10:0] wb_b, input bit set_ill);
        for (int i = 0; i < fw; i++) push(ins, c, j, 1'b1, S_FETCH, RD | IFB, RD | IFB);
        push(ins, c, j, 1'b0, S_FETCH, RD | IFB | IRL, RD | IFB | IRL);
        push(ins, c, j, 1'b0, S_EXEC, ex, ex);
        if (set_ill) ill_exp = 1'b1;
        if (mw >= 0) begin
            for (int i = 0; i < mw; i++) push(ins, c, j, 1'b1, S_MEM, mb, mb);
            push(ins, c, j, 1'b0, S_MEM, mb, mb);
        end
        for (int i = 0; i < lw; i++) push(ins, c, j, 1'b0, S_MDW, NONE, NONE);
        push(ins, c, j, 1'b0, S_WB, PCW | wb_a, PCW | wb_b);
    endtask

    // Called at posedge+1; n < 0 drains the queue.
    task automatic play(input string name, input int n);
        int k;
        logic [W-1:0] e;
        logic [34:0] s;
        k = 0;
        while (stim_q.size() > 0 && (n < 0 || k < n)) begin
            s = stim_q.pop_front();
            cond = s[34];
            jrz  = s[33];
            drive(s[31:0], s[32]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL %s dut_a cycle %0d: got %h expected %h", name, k, obs_a, e);
            end
            if (b_on) begin
                checks++;
                if (exp_b_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s dut_b cycle %0d: no expected entry", name, k);
                end else begin
                    e = exp_b_q.pop_front();
                    if (obs_b !== e) begin
                        errors++;
                        $display("FAIL %s dut_b cycle %0d: got %h expected %h", name, k, obs_b, e);
                    end
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_reset(input string name);
        stim_q.delete();
        exp_q.delete();
        exp_b_q.delete();
        rst_n = 1'b0;
        drive(32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_a !== {S_FETCH, ACT}) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, obs_a, {S_FETCH, ACT});
        end
        ill_exp = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset_a");
        checks++;
        if (obs_b !== {S_FETCH, ACT}) begin
            errors++;
            $display("FAIL reset_b: got %h expected %h", obs_b, {S_FETCH, ACT});
        end
    endtask

    task automatic test_alu();
        logic [31:0] tbl [5];
        tbl = '{32'h34420001, 32'h3c01abcd, 32'h00021080, 32'h0043082a, 32'h00001012};
        sched(I_ADDU, 0, 0, 0, -1, 0, NONE, NONE, RW, RW, 0);
        play("addu", -1);
        foreach (tbl[i]) sched(tbl[i], 0, 0, $urandom_range(0, 3), -1, 0, NONE, NONE, RW, RW, 0);
        play("alu_table", -1);
    endtask

    task automatic test_load_store();
        sched(I_LW, 0, 0, 2, 3, 0, NONE, RD, RW, RW, 0);
        play("lw_wait", -1);
        sched(I_SW, 0, 0, $urandom_range(0, 2), $urandom_range(0, 3), 0, NONE, WR, NONE, NONE, 0);
        sched(32'h80220000, 0, 0, 0, 0, 0, NONE, RD, RW, RW, 0);
        play("sw_lb", -1);
    endtask

    task automatic test_branch_slot();
        b_on = 1'b1;
        rst_b_n = 1'b1;
        sched(I_BEQ, 1, 0, 0, -1, 0, TGT, NONE, NONE, PCS, 0);
        sched(I_ADDIU, 0, 0, 0, -1, 0, NONE, NONE, RW | PCS, RW, 0);
        play("beq_taken", -1);
        b_on = 1'b0;
        rst_b_n = 1'b0;
        sched(32'h14220002, 0, 0, 0, -1, 0, NONE, NONE, NONE, NONE, 0);
        sched(I_ADDIU, 0, 0, 0, -1, 0, NONE, NONE, RW, RW, 0);
        play("bne_not_taken", -1);
        sched(32'h08000010, 0, 0, 0, -1, 0, TGT, NONE, NONE, NONE, 0);
        sched(I_BEQ, 1, 0, 1, -1, 0, NONE, NONE, PCS, PCS, 0);
        sched(I_ADDU, 0, 0, 0, -1, 0, NONE, NONE, RW, RW, 0);
        play("branch_in_slot", -1);
        sched(32'h04310004, 0, 0, 0, -1, 0, NONE, NONE, RW, RW, 0);
        sched(32'h0c000020, 0, 0, 0, -1, 0, TGT, NONE, RW, RW, 0);
        sched(I_ADDIU, 0, 0, 0, -1, 0, NONE, NONE, RW | PCS, RW, 0);
        play("links", -1);
    endtask

    task automatic test_muldiv();
        sched(32'h0043001a, 0, 0, 0, -1, 31, NONE, NONE, SPC, SPC, 0);
        play("div", -1);
        sched(I_MULT, 0, 0, 0, -1, 0, NONE, NONE, SPC, SPC, 0);
        sched(32'h00400011, 0, 0, 0, -1, 0, NONE, NONE, SPC, SPC, 0);
        sched(32'h00001010, 0, 0, 0, -1, 0, NONE, NONE, RW, RW, 0);
        sched(32'h0043001b, 0, 0, 1, -1, 31, NONE, NONE, SPC, SPC, 0);
        play("mult_mt_divu", -1);
    endtask

    task automatic test_illegal();
        sched(I_BAD, 0, 0, 0, -1, 0, NONE, NONE, NONE, NONE, 1);
        sched(32'h0000003f, 0, 0, 0, -1, 0, NONE, NONE, NONE, NONE, 1);
        sched(I_ADDU, 0, 0, 0, -1, 0, NONE, NONE, RW, RW, 0);
        play("illegal", -1);
    endtask

    task automatic test_halt();
        sched(32'h00000008, 0, 1, 0, -1, 0, TGT, NONE, NONE, NONE, 0);
        sched(I_ADDIU, 0, 0, 0, -1, 0, NONE, NONE, RW | PCS, RW, 0);
        for (int i = 0; i < 100; i++)
            push(I_ADDU, 0, 0, 1'($urandom_range(0, 1)), S_HALT, NONE, NONE);
        play("jr_halt", -1);
    endtask

    task automatic test_async_reset();
        do_reset("reset_from_halt");
        sched(I_BAD, 0, 0, 0, -1, 0, NONE, NONE, NONE, NONE, 1);
        sched(I_LW, 0, 0, 0, 6, 0, NONE, RD, RW, RW, 0);
        play("pre_async", 7);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== {S_FETCH, ACT}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs_a, {S_FETCH, ACT});
        end
        stim_q.delete();
        exp_q.delete();
        ill_exp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sched(I_ADDU, 0, 0, 1, -1, 0, NONE, NONE, RW, RW, 0);
        play("after_async", -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            int k, fw, mw;
            k  = $urandom_range(0, 4);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            case (k)
                0: sched(I_ADDU, 0, 0, fw, -1, 0, NONE, NONE, RW, RW, 0);
                1: sched(I_LW, 0, 0, fw, mw, 0, NONE, RD, RW, RW, 0);
                2: sched(I_SW, 0, 0, fw, mw, 0, NONE, WR, NONE, NONE, 0);
                3: sched(I_MULT, 0, 0, fw, -1, 0, NONE, NONE, SPC, SPC, 0);
                default: sched(I_ORI, 0, 0, fw, -1, 0, NONE, NONE, RW, RW, 0);
            endcase
        end
        play("back_to_back", -1);
    endtask

    initial begin
        rst_n = 1'b0;
        rst_b_n = 1'b0;
        cond = 1'b0;
        jrz = 1'b0;
        drive(32'h0, 1'b0);
        test_reset();
        test_alu();
        test_load_store();
        test_branch_slot();
        test_muldiv();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
